modred_pm256: RTL and testbench

Pseudo-Mersenne modular reducer that consumes the 512-bit product stream of the 256x256 Karatsuba multiplier and returns R = P mod p, where p = 2^256 - C. It is the downstream end of the multiplier's valid-only product interface and closes the modular-multiplication datapath. The reducer is iterative (8-cycle initiation interval), so it buffers bursts from the full-rate multiplier in an optional input FIFO and reports drops on a sticky error flag.

---
 rtl/modred_pm256.sv | 165 ++++++++++++++++
 tb/tb_modred_pm256.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/modred_pm256.sv
// modred_pm256: iterative pseudo-Mersenne reducer, R = P mod p with p = 2^256 - C.
// A 512-bit product is folded 64 bits of the high half at a time into a wide
// accumulator. The accumulator's overhang is then folded once more, and the result
// gets two conditional corrections.
// Optional input FIFO: define MODRED_FIFO_EN to buffer bursts (DEPTH entries).
// Without it, products arriving while the engine is busy are dropped.
module modred_pm256 #(
  parameter int             C_W   = 33,
  parameter logic [C_W-1:0] C     = 33'h1_0000_03D1,
  parameter int             DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [511:0] P_in,
  output logic         in_afull,
  output logic         overflow,
  output logic [255:0] R,
  output logic         out_valid
);

  localparam int ACC_W = 256 + C_W + 1;
  localparam logic [256:0] P_MOD = {1'b1, 256'b0} - 257'(C);

  typedef enum logic [2:0] {IDLE, FOLD1, FOLD2, CORR1, CORR2} state_t;

  state_t             state_q, state_d;
  logic [255:0]       hi_q, hi_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [1:0]         chunk_q, chunk_d;
  logic [256:0]       r_q, r_d;
  logic [255:0]       R_q, R_d;
  logic               out_valid_q, out_valid_d;
  logic               overflow_q, overflow_d;

  logic               opAvail;
  logic [511:0]       opData;
  logic               dropIn;

`ifdef MODRED_FIFO_EN
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] AFULL_C = DEPTH_C - 1'b1;

  logic [511:0]   mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [PTR_W:0] count_q;
  logic           push, pop;

  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign push     = in_valid && ((count_q < DEPTH_C) || pop);
  assign opAvail  = pop;
  assign opData   = mem[rdPtr_q];
  assign dropIn   = in_valid && !push;
  assign in_afull = (count_q >= AFULL_C);

  // FIFO storage; contents are meaningless until counted in, so no reset.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr_q] <= P_in;
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end
`else
  assign opAvail  = in_valid && (state_q == IDLE);
  assign opData   = P_in;
  assign dropIn   = in_valid && (state_q != IDLE);
  assign in_afull = (state_q != IDLE);
`endif

  logic [63:0]      hiChunk;
  logic [64+C_W-1:0] mulChunk;
  logic [ACC_W-1:0] shiftedChunk;
  logic [2*C_W:0]   foldProd;
  logic [255:0]     rSub;

  // Datapath helpers: one 64xC_W partial product per FOLD1 cycle, one overhang fold.
  // After CORR1, r < 2^256, so the final subtraction only needs the low 256 bits.
  assign hiChunk      = hi_q[{chunk_q, 6'b0} +: 64];
  assign mulChunk     = hiChunk * C;
  assign shiftedChunk = ACC_W'(mulChunk) << {chunk_q, 6'b0};
  assign foldProd     = acc_q[ACC_W-1:256] * C;
  assign rSub         = r_q[255:0] - P_MOD[255:0];

  // Next-state and datapath updates for the fold/correct sequence.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    acc_d       = acc_q;
    chunk_d     = chunk_q;
    r_d         = r_q;
    R_d         = R_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q | dropIn;
    case (state_q)
      IDLE: begin
        if (opAvail) begin
          hi_d    = opData[511:256];
          acc_d   = ACC_W'(opData[255:0]);
          chunk_d = 2'd0;
          state_d = FOLD1;
        end
      end
      FOLD1: begin
        acc_d   = acc_q + shiftedChunk;
        chunk_d = chunk_q + 2'd1;
        if (chunk_q == 2'd3) state_d = FOLD2;
      end
      FOLD2: begin
        r_d     = 257'(acc_q[255:0]) + 257'(foldProd);
        state_d = CORR1;
      end
      CORR1: begin
        if (r_q[256]) r_d = 257'(r_q[255:0]) + 257'(C);
        state_d = CORR2;
      end
      CORR2: begin
        R_d         = (r_q >= P_MOD) ? rSub : r_q[255:0];
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight product.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      acc_q       <= '0;
      chunk_q     <= '0;
      r_q         <= '0;
      R_q         <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      acc_q       <= acc_d;
      chunk_q     <= chunk_d;
      r_q         <= r_d;
      R_q         <= R_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign R         = R_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_modred_pm256.sv
// Scoreboard bench for modred_pm256 (default C, secp256k1 modulus).
// Honours MODRED_FIFO_EN the same way as the design.
module tb_modred_pm256;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [511:0] P_in = '0;
  logic         in_afull;
  logic         overflow;
  logic [255:0] R;
  logic         out_valid;

`ifdef MODRED_FIFO_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 7;
`endif

  localparam logic [511:0] ONE_256 = 512'b1 << 256;
  localparam logic [511:0] C_512   = 512'h1000003D1;

  modred_pm256 dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .P_in     (P_in),
    .in_afull (in_afull),
    .overflow (overflow),
    .R        (R),
    .out_valid(out_valid)
  );

  // Free-running clock and edge counter used for latency checks.
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [255:0] r;
    int           due;
    string        name;
  } exp_t;
  exp_t sbQ[$];

  // Bit-serial long-division reference: shift in one bit, subtract p when needed.
  function automatic logic [255:0] refMod(input logic [511:0] x);
    logic [257:0] p258;
    logic [257:0] r;
    p258 = {2'b01, 256'b0} - 258'h1000003D1;
    r = '0;
    for (int i = 511; i >= 0; i--) begin
      r = {r[256:0], x[i]};
      if (r >= p258) r = r - p258;
    end
    return r[255:0];
  endfunction

  function automatic logic [511:0] burstP(input int i);
    logic [31:0] w;
    w = 32'(i + 1) * 32'h9E3779B9;
    return {16{w}};
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one in_valid pulse; if a result is expected, queue it with its due edge.
  task automatic applyStimulus(input logic [511:0] data, input bit expectOut, input int lat,
                               input logic [255:0] expR, input string name);
    exp_t e;
    P_in     = data;
    in_valid = 1'b1;
    if (expectOut) begin
      e.r    = expR;
      e.due  = cyc + 1 + lat;
      e.name = name;
      sbQ.push_back(e);
    end
    @(negedge clock);
    in_valid = 1'b0;
    P_in     = '0;
  endtask

  task automatic waitDrain(input int maxCyc);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < maxCyc) begin
      @(negedge clock);
      n++;
    end
    if (sbQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout pending=%0d required=0", sbQ.size());
      sbQ.delete();
    end
    @(negedge clock);
  endtask

  // Monitor: every out_valid pulse must match the oldest expectation, on time.
  always @(negedge clock) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_out_valid actual=1 required=0 R=%h", R);
      end else begin
        e = sbQ.pop_front();
        checks++;
        if (R !== e.r) begin
          failures++;
          $display("[TB] FAIL %s_R actual=%h required=%h", e.name, R, e.r);
        end
        checks++;
        if (cyc != e.due) begin
          failures++;
          $display("[TB] FAIL %s_latency actual_edge=%0d required_edge=%0d", e.name, cyc, e.due);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [511:0] p512;
    logic [511:0] pm1;
    logic [511:0] vecP [6];
    logic [255:0] vecR [6];
    string        vecN [6];

    p512 = ONE_256 - C_512;
    pm1  = p512 - 512'd1;
    vecP[0] = p512;           vecR[0] = 256'd0;                 vecN[0] = "p";
    vecP[1] = ONE_256;        vecR[1] = 256'h1000003D1;         vecN[1] = "two256";
    vecP[2] = ONE_256 << 1;   vecR[2] = 256'h2000007A2;         vecN[2] = "two257";
    vecP[3] = pm1;            vecR[3] = pm1[255:0];             vecN[3] = "p_minus_1";
    vecP[4] = pm1 * pm1;      vecR[4] = 256'd1;                 vecN[4] = "pm1_squared";
    vecP[5] = {512{1'b1}};    vecR[5] = refMod({512{1'b1}});    vecN[5] = "all_ones";

    // Reset state.
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_R", R, 256'd0);
    checkOutput("reset_out_valid", 256'(out_valid), 256'd0);
    checkOutput("reset_overflow", 256'(overflow), 256'd0);
    checkOutput("reset_in_afull", 256'(in_afull), 256'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Zero operand and basic latency.
    applyStimulus(512'd0, 1'b1, LAT, 256'd0, "zeros");
    waitDrain(30);
    checkOutput("zeros_overflow", 256'(overflow), 256'd0);

    // Directed reduction vectors.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecP[i], 1'b1, LAT, vecR[i], vecN[i]);
      waitDrain(30);
    end

`ifdef MODRED_FIFO_EN
    // Burst of 8 into a 4-deep FIFO: 5 accepted, 3 dropped, results 8 cycles apart.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(burstP(i), (i < 5), 8 + 7 * i, refMod(burstP(i)), $sformatf("burst%0d", i));
      if (i == 3) checkOutput("burst_afull_4th", 256'(in_afull), 256'd1);
      if (i == 4) checkOutput("burst_overflow_before_drop", 256'(overflow), 256'd0);
      if (i == 5) checkOutput("burst_overflow_after_drop", 256'(overflow), 256'd1);
    end
    waitDrain(80);
`else
    // No FIFO: second pulse 3 cycles later hits a busy engine and is dropped.
    applyStimulus(burstP(1), 1'b1, 7, refMod(burstP(1)), "nofifo_first");
    checkOutput("nofifo_afull_busy", 256'(in_afull), 256'd1);
    repeat (2) @(negedge clock);
    checkOutput("nofifo_overflow_before", 256'(overflow), 256'd0);
    applyStimulus(burstP(2), 1'b0, 7, 256'd0, "nofifo_second");
    checkOutput("nofifo_overflow_after", 256'(overflow), 256'd1);
    waitDrain(30);
`endif

    // Reset in mid-operation: three products issued, reset during the fold.
    applyStimulus(ONE_256, 1'b0, LAT, 256'd0, "rst_a");
    applyStimulus(ONE_256 << 1, 1'b0, LAT, 256'd0, "rst_b");
    applyStimulus(burstP(7), 1'b0, LAT, 256'd0, "rst_c");
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_R_async", R, 256'd0);
    checkOutput("midrst_overflow_async", 256'(overflow), 256'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (15) @(negedge clock);
    checkOutput("postrst_R", R, 256'd0);
    checkOutput("postrst_overflow", 256'(overflow), 256'd0);
    applyStimulus(ONE_256, 1'b1, LAT, 256'h1000003D1, "postrst_two256");
    waitDrain(30);

    checkOutput("final_queue_empty", 256'(sbQ.size()), 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
